// File: rtl/core_loader.sv
// Host-side loader: decodes framed byte commands into instruction/register writes
// for the core's setup interface and releases the core into run on START.
module core_loader #(
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int IMEM_WORDS     = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  i_byte,
  input  logic        i_byte_valid,
  output logic        o_byte_ready,
  output logic        o_setup,
  output logic [31:0] o_pc_start_addr,
  output logic [31:0] o_inst_mem_addr,
  output logic [31:0] o_inst_mem_data,
  output logic        o_inst_wr_strobe,
  output logic [4:0]  o_load_reg_addr,
  output logic [31:0] o_load_reg_data,
  output logic        o_reg_wr_strobe,
  output logic [1:0]  o_err_code,
  output logic [15:0] o_word_count
);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_COMMIT, S_RUN} state_e;

  localparam logic [7:0] CMD_IWRITE = 8'hA1;
  localparam logic [7:0] CMD_RWRITE = 8'hA2;
  localparam logic [7:0] CMD_START  = 8'hA3;
  localparam logic [7:0] CMD_HALT   = 8'hA4;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_CMD     = 2'd1;
  localparam logic [1:0] ERR_ADDR    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam int            TW         = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0]   IMEM_BYTES = 32'(IMEM_WORDS * 4);

  state_e        state_q, state_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   data_q, data_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          setup_q, setup_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   iaddr_q, iaddr_d;
  logic [31:0]   idata_q, idata_d;
  logic          istb_q, istb_d;
  logic [4:0]    raddr_q, raddr_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          rstb_q, rstb_d;
  logic [1:0]    err_q, err_d;
  logic [15:0]   wcnt_q, wcnt_d;

  logic          xfer;
  logic [31:0]   addr_ins;
  logic [31:0]   data_ins;

  // Ready drops only during reset and the single commit cycle.
  assign o_byte_ready = ~rst & (state_q != S_COMMIT);
  assign xfer         = i_byte_valid & o_byte_ready;

  // Results are registered on the edge that accepts a packet's last byte, so
  // they are visible (with the strobe) during the COMMIT cycle that follows.
  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    data_d   = data_q;
    timer_d  = '0;
    setup_d  = setup_q;
    pc_d     = pc_q;
    iaddr_d  = iaddr_q;
    idata_d  = idata_q;
    istb_d   = 1'b0;
    raddr_d  = raddr_q;
    rdata_d  = rdata_q;
    rstb_d   = 1'b0;
    err_d    = err_q;
    wcnt_d   = wcnt_q;
    addr_ins = addr_q;
    addr_ins[{cnt_q, 3'b000} +: 8] = i_byte;
    data_ins = data_q;
    data_ins[{cnt_q, 3'b000} +: 8] = i_byte;

    case (state_q)
      S_IDLE: begin
        if (xfer) begin
          cmd_d  = i_byte;
          cnt_d  = 2'd0;
          addr_d = '0;
          data_d = '0;
          case (i_byte)
            CMD_IWRITE, CMD_RWRITE, CMD_START: state_d = S_ADDR;
            CMD_HALT: begin
              state_d = S_COMMIT;
              setup_d = 1'b1;
              err_d   = ERR_NONE;
            end
            default: err_d = ERR_CMD;
          endcase
        end
      end
      S_ADDR: begin
        if (xfer) begin
          addr_d = addr_ins;
          cnt_d  = cnt_q + 2'd1;
          if (cmd_q == CMD_RWRITE || cnt_q == 2'd3) begin
            cnt_d = 2'd0;
            if (cmd_q == CMD_START) begin
              state_d = S_COMMIT;
              pc_d    = addr_ins;
              err_d   = ERR_NONE;
            end else begin
              state_d = S_DATA;
            end
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          data_d = data_ins;
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = S_COMMIT;
            if (cmd_q == CMD_IWRITE) begin
              if (addr_q[1:0] == 2'b00 && addr_q < IMEM_BYTES) begin
                iaddr_d = addr_q;
                idata_d = data_ins;
                istb_d  = 1'b1;
                wcnt_d  = wcnt_q + 16'd1;
                err_d   = ERR_NONE;
              end else begin
                err_d = ERR_ADDR;
              end
            end else begin
              if (addr_q[7:5] == 3'b000) begin
                raddr_d = addr_q[4:0];
                rdata_d = data_ins;
                rstb_d  = 1'b1;
                err_d   = ERR_NONE;
              end else begin
                err_d = ERR_ADDR;
              end
            end
          end
        end
      end
      S_COMMIT: begin
        if (cmd_q == CMD_START) begin
          state_d = S_RUN;
          setup_d = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (xfer && i_byte == CMD_HALT) begin
          cmd_d   = CMD_HALT;
          state_d = S_COMMIT;
          setup_d = 1'b1;
          err_d   = ERR_NONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Inter-byte timeout only runs while a packet is partially received.
    if ((state_q == S_ADDR || state_q == S_DATA) && !xfer) begin
      if (timer_q == TIMER_LAST) begin
        state_d = S_IDLE;
        err_d   = ERR_TIMEOUT;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cmd_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      timer_q <= '0;
      setup_q <= 1'b1;
      pc_q    <= '0;
      iaddr_q <= '0;
      idata_q <= '0;
      istb_q  <= 1'b0;
      raddr_q <= '0;
      rdata_q <= '0;
      rstb_q  <= 1'b0;
      err_q   <= ERR_NONE;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      timer_q <= timer_d;
      setup_q <= setup_d;
      pc_q    <= pc_d;
      iaddr_q <= iaddr_d;
      idata_q <= idata_d;
      istb_q  <= istb_d;
      raddr_q <= raddr_d;
      rdata_q <= rdata_d;
      rstb_q  <= rstb_d;
      err_q   <= err_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign o_setup          = setup_q;
  assign o_pc_start_addr  = pc_q;
  assign o_inst_mem_addr  = iaddr_q;
  assign o_inst_mem_data  = idata_q;
  assign o_inst_wr_strobe = istb_q;
  assign o_load_reg_addr  = raddr_q;
  assign o_load_reg_data  = rdata_q;
  assign o_reg_wr_strobe  = rstb_q;
  assign o_err_code       = err_q;
  assign o_word_count     = wcnt_q;

endmodule
